// File: rtl/div_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// div_ctrl_pkg
// Shared definitions for the EXE-stage divide controller:
//   - op bit positions of the one-hot {mod_wu, div_wu, mod_w, div_w} field
//   - op class masks (signed ops, remainder-producing ops)
//   - iteration counter width and FSM state encoding
//   - small two's-complement helpers used by the sign fixup logic
// -----------------------------------------------------------------------------
package div_ctrl_pkg;

  localparam int DIV_DW        = 32;
  localparam int DIV_CNT_W     = 5;

  localparam int DIV_OP_DIV_W  = 0;
  localparam int DIV_OP_MOD_W  = 1;
  localparam int DIV_OP_DIV_WU = 2;
  localparam int DIV_OP_MOD_WU = 3;

  // Ops whose operands are interpreted as two's-complement.
  localparam logic [3:0] DIV_OP_SIGNED_MASK = (4'b0001 << DIV_OP_DIV_W) | (4'b0001 << DIV_OP_MOD_W);
  // Ops that return the remainder instead of the quotient.
  localparam logic [3:0] DIV_OP_MOD_MASK    = (4'b0001 << DIV_OP_MOD_W) | (4'b0001 << DIV_OP_MOD_WU);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } div_state_e;

  // Two's-complement negate.
  function automatic logic [DIV_DW-1:0] neg_w(input logic [DIV_DW-1:0] v);
    return ~v + {{(DIV_DW-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of v when it is a signed operand, raw value otherwise.
  function automatic logic [DIV_DW-1:0] mag_w(input logic [DIV_DW-1:0] v, input logic is_signed);
    return (is_signed && v[DIV_DW-1]) ? neg_w(v) : v;
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// -----------------------------------------------------------------------------
// div_ctrl_if
// Request/response bundle between the EXE stage (master) and the divide
// controller (slave).
//   req_valid/req_ready : request handshake, op/src1/src2 carried with it
//   flush               : synchronous kill from branch/exception
//   res_valid/res_ready : result handshake, result carried with it
//   busy                : controller is not idle (EXE holds ready_go low)
// -----------------------------------------------------------------------------
interface div_ctrl_if;
  import div_ctrl_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [3:0]        op;
  logic [DIV_DW-1:0] src1;
  logic [DIV_DW-1:0] src2;
  logic              flush;
  logic              res_valid;
  logic              res_ready;
  logic [DIV_DW-1:0] result;
  logic              busy;

  modport master (
    output req_valid, op, src1, src2, flush, res_ready,
    input  req_ready, res_valid, result, busy
  );

  modport slave (
    input  req_valid, op, src1, src2, flush, res_ready,
    output req_ready, res_valid, result, busy
  );

endinterface

// File: rtl/div_ctrl_iter_core.sv
// -----------------------------------------------------------------------------
// div_iter_core
// Radix-2 restoring shift-subtract datapath. One quotient bit per step.
//   clk, resetn : clock, asynchronous active-low reset
//   init        : load dividend/divisor magnitudes, clear remainder
//   step        : perform one shift-subtract iteration
//   dvd_in      : dividend magnitude
//   dvs_in      : divisor magnitude
//   quot        : quotient (the dividend register fills with quotient bits)
//   rem         : partial / final remainder
// -----------------------------------------------------------------------------
module div_iter_core
  import div_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              init,
  input  logic              step,
  input  logic [DIV_DW-1:0] dvd_in,
  input  logic [DIV_DW-1:0] dvs_in,
  output logic [DIV_DW-1:0] quot,
  output logic [DIV_DW-1:0] rem
);

  logic [DIV_DW-1:0] dvd_r;
  logic [DIV_DW-1:0] dvs_r;
  logic [DIV_DW-1:0] rem_r;
  logic [DIV_DW:0]   trial_s;
  logic [DIV_DW-1:0] rem_nx_s;

  // Trial subtraction: the partial remainder is always below the divisor, so
  // the 33-bit difference's MSB is a reliable borrow flag.
  always_comb begin
    trial_s = {rem_r, dvd_r[DIV_DW-1]} - {1'b0, dvs_r};
    if (!trial_s[DIV_DW]) begin
      rem_nx_s = trial_s[DIV_DW-1:0];
    end else begin
      rem_nx_s = {rem_r[DIV_DW-2:0], dvd_r[DIV_DW-1]};
    end
  end

  // Datapath registers: load on init, shift one bit per step, else hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dvd_r <= {DIV_DW{1'b0}};
      dvs_r <= {DIV_DW{1'b0}};
      rem_r <= {DIV_DW{1'b0}};
    end else if (init) begin
      dvd_r <= dvd_in;
      dvs_r <= dvs_in;
      rem_r <= {DIV_DW{1'b0}};
    end else if (step) begin
      rem_r <= rem_nx_s;
      dvd_r <= {dvd_r[DIV_DW-2:0], ~trial_s[DIV_DW]};
    end else begin
      dvd_r <= dvd_r;
      dvs_r <= dvs_r;
      rem_r <= rem_r;
    end
  end

  assign quot = dvd_r;
  assign rem  = rem_r;

endmodule

// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
// Multi-cycle divide controller for div.w / mod.w / div.wu / mod.wu.
// Sequences div_iter_core through IDLE -> PREP -> CALC(x32) -> FIX -> DONE,
// applies sign fixups and returns the result over a valid/ready handshake.
// Parameters:
//   DW        : operand/result width (32 only)
//   ZERO_FAST : 1 -> a zero divisor skips CALC (2-cycle latency)
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   dif         : div_ctrl_if.slave (request, flush, result, busy)
// -----------------------------------------------------------------------------
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DW        = 32,
  parameter bit ZERO_FAST = 1'b1
) (
  input  logic       clk,
  input  logic       resetn,
  div_ctrl_if.slave  dif
);

  div_state_e           state_r;
  div_state_e           state_nx_s;
  logic [DIV_CNT_W-1:0] cnt_r;
  logic                 signed_r;
  logic                 is_mod_r;
  logic [DW-1:0]        src1_r;
  logic [DW-1:0]        src2_r;
  logic                 q_neg_r;
  logic                 r_neg_r;
  logic [DW-1:0]        result_r;
  logic                 res_valid_r;
  logic                 busy_r;

  logic                 accept_s;
  logic                 core_init_s;
  logic                 core_step_s;
  logic                 dvs_zero_s;
  logic [DW-1:0]        quot_s;
  logic [DW-1:0]        rem_s;
  logic [DW-1:0]        fix_val_s;

  assign dvs_zero_s = (src2_r == {DW{1'b0}});

  div_iter_core u_core (
    .clk    (clk),
    .resetn (resetn),
    .init   (core_init_s),
    .step   (core_step_s),
    .dvd_in (mag_w(src1_r, signed_r)),
    .dvs_in (mag_w(src2_r, signed_r)),
    .quot   (quot_s),
    .rem    (rem_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state and datapath controls; flush wins over every state.
  always_comb begin
    state_nx_s  = state_r;
    accept_s    = 1'b0;
    core_init_s = 1'b0;
    core_step_s = 1'b0;
    if (dif.flush) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (dif.req_valid) begin
            accept_s   = 1'b1;
            state_nx_s = ST_PREP;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_PREP: begin
          core_init_s = 1'b1;
          if (dvs_zero_s && ZERO_FAST) begin
            state_nx_s = ST_FIX;
          end else begin
            state_nx_s = ST_CALC;
          end
        end
        ST_CALC: begin
          core_step_s = 1'b1;
          if (cnt_r == {DIV_CNT_W{1'b0}}) begin
            state_nx_s = ST_FIX;
          end else begin
            state_nx_s = ST_CALC;
          end
        end
        ST_FIX: begin
          state_nx_s = ST_DONE;
        end
        ST_DONE: begin
          if (dif.res_ready) begin
            if (dif.req_valid) begin
              accept_s   = 1'b1;
              state_nx_s = ST_PREP;
            end else begin
              state_nx_s = ST_IDLE;
            end
          end else begin
            state_nx_s = ST_DONE;
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
        end
      endcase
    end
  end

  // Sign fixup and quotient/remainder select. A zero divisor always yields
  // all-ones / the raw dividend regardless of signedness or path taken.
  always_comb begin
    fix_val_s = {DW{1'b0}};
    if (dvs_zero_s) begin
      fix_val_s = is_mod_r ? src1_r : {DW{1'b1}};
    end else if (is_mod_r) begin
      fix_val_s = r_neg_r ? neg_w(rem_s) : rem_s;
    end else begin
      fix_val_s = q_neg_r ? neg_w(quot_s) : quot_s;
    end
  end

  // Request capture, sign flags and iteration counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      signed_r <= 1'b0;
      is_mod_r <= 1'b0;
      src1_r   <= {DW{1'b0}};
      src2_r   <= {DW{1'b0}};
      q_neg_r  <= 1'b0;
      r_neg_r  <= 1'b0;
      cnt_r    <= {DIV_CNT_W{1'b0}};
    end else if (accept_s) begin
      signed_r <= |(dif.op & DIV_OP_SIGNED_MASK);
      is_mod_r <= |(dif.op & DIV_OP_MOD_MASK);
      src1_r   <= dif.src1;
      src2_r   <= dif.src2;
    end else if (core_init_s) begin
      q_neg_r  <= signed_r & (src1_r[DW-1] ^ src2_r[DW-1]);
      r_neg_r  <= signed_r & src1_r[DW-1];
      cnt_r    <= {DIV_CNT_W{1'b1}};
    end else if (core_step_s) begin
      cnt_r    <= cnt_r - {{(DIV_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r    <= cnt_r;
    end
  end

  // Registered outputs: result loads only on an unflushed FIX, valid/busy
  // follow the next state so they drop in the same cycle as a flush.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      result_r    <= {DW{1'b0}};
      res_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      if ((state_r == ST_FIX) && !dif.flush) begin
        result_r <= fix_val_s;
      end else begin
        result_r <= result_r;
      end
      res_valid_r <= (state_nx_s == ST_DONE);
      busy_r      <= (state_nx_s != ST_IDLE);
    end
  end

  assign dif.req_ready = (state_r == ST_IDLE) | ((state_r == ST_DONE) & dif.res_ready);
  assign dif.res_valid = res_valid_r;
  assign dif.result    = result_r;
  assign dif.busy      = busy_r;

endmodule
